regfile_bypass_sb: RTL
======================

Name: regfile_bypass_sb

Overview:
- Parametrised successor to the CPU architectural register file.
- Adds NUM_READ read ports, two write ports with defined priority, and optional same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard with per-read-port busy flags, used by the decode stage for load-use hazard stalls.
- Sits between decode (reads, scoreboard set) and writeback (ALU port 0, load port 1).

Parameters:
- ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32, register data width.
- NUM_READ, 2, number of combinational read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports and clears busy on the read ports; 0 = stored value only.
- DEBUG_REG, 10, index driven on dbg_data (a0 by default).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_READ x ADDRESS_WIDTH  read addresses, packed, port i = slice i.
- rd_data  out  NUM_READ x DATA_WIDTH  read data per port.
- rd_busy  out  NUM_READ  1 = addressed register has a pending write.
- we  in  2  write enables; index 0 = ALU writeback, index 1 = load writeback.
- wr_addr  in  2 x ADDRESS_WIDTH  write addresses.
- wr_data  in  2 x DATA_WIDTH  write data.
- sb_set  in  1  mark sb_addr as pending (load issued).
- sb_addr  in  ADDRESS_WIDTH  scoreboard destination.
- dbg_data  out  DATA_WIDTH  stored value of register DEBUG_REG, no bypass.

Behaviour:
- Storage: 2**ADDRESS_WIDTH x DATA_WIDTH array plus a busy bit per register.
- Reset (rst=1 at an edge):
  - All registers and busy bits become 0.
  - Writes and sb_set in that cycle are ignored.
  - Reads during the reset cycle show pre-edge contents, with bypass suppressed.
- After the reset edge, every rd_data, rd_busy and dbg_data reads 0.
- Register 0:
  - Writes are discarded.
  - Busy bit never sets.
  - rd_data = 0 and rd_busy = 0 for address 0, including under bypass.
- Write, latency 1: on an edge with rst=0 and we[k]=1 and wr_addr[k]!=0, register wr_addr[k] <= wr_data[k].
- Both write ports to the same address in one cycle: port 1 wins for both data and bypass.
- Read (combinational, 0 latency):
  - BYPASS=1: if rst=0 and any effective write targets rd_addr[i], rd_data[i] = that write's data (port 1 priority); otherwise the stored value.
  - BYPASS=0: always the stored value.
- Scoreboard:
  - Edge with sb_set=1, sb_addr!=0: busy[sb_addr] <= 1.
  - Effective write on either port: busy[wr_addr] <= 0.
  - Same address set and cleared in one cycle: set wins (new pending write is younger).
  - sb_set on an already-busy register: remains 1, no counting.
- rd_busy[i]:
  - BYPASS=1: busy[rd_addr[i]] AND NOT (an effective write to rd_addr[i] this cycle).
  - BYPASS=0: busy[rd_addr[i]].
- dbg_data: stored array value of DEBUG_REG; updates one cycle after the write.
- No X propagation: every output is driven from reset onward.

Decomposition:
- Package regfile_pkg:
  - Default constants: ADDRESS_WIDTH, DATA_WIDTH.
  - WB_ALU=0, WB_LOAD=1 port indices.
  - Typedefs reg_addr_t and reg_data_t.
- Sub-module regfile_scoreboard holds the busy vector, set/clear priority and the per-port busy lookup.
- The data array, write priority and bypass mux stay in the top module.

Test Plan:
- Reset then read:
  - Stimulus: preload r5=0x1234, assert rst for one cycle.
  - Required: rd_data for r5 = 0, rd_busy=0, dbg_data=0.
  - Stimulus: we[0] to r5 in the reset cycle.
  - Required: ignored, r5 still 0.
- Write and bypass:
  - Stimulus: we[0]=1, wr_addr=7, wr_data=0xDEADBEEF, rd_addr[0]=7 in the same cycle.
  - Required: BYPASS=1 shows 0xDEADBEEF that cycle; BYPASS=0 shows 0 that cycle and 0xDEADBEEF next cycle.
- Dual-write collision:
  - Stimulus: we=2'b11, both addresses 3, data 0x11 (port 0) and 0x22 (port 1).
  - Required: bypass read and stored value = 0x22.
- x0 hardwire:
  - Stimulus: write 0xFFFFFFFF to r0, sb_set to r0.
  - Required: rd_data=0 and rd_busy=0 on all ports, same cycle and next cycle.
- Scoreboard:
  - sb_set r9 → next cycle rd_busy=1 for r9.
  - Load writeback we[1] to r9 → rd_busy=0 that cycle (BYPASS=1) and stays 0.
  - sb_set r9 together with we[0] to r9 in the same cycle → busy=1 afterwards.
- Debug port: write 0x2A to r10 → dbg_data=0x2A one cycle later, unchanged during the write cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared constants and types for the bypassing register file.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

   localparam int ADDRESS_WIDTH = 5;
   localparam int DATA_WIDTH    = 32;

   localparam int WB_ALU  = 0;
   localparam int WB_LOAD = 1;

   typedef logic [ADDRESS_WIDTH-1:0] reg_addr_t;
   typedef logic [DATA_WIDTH-1:0]    reg_data_t;

endpackage
`default_nettype wire

// File: rtl/regfile_bypass_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bypass_sb_if
// Purpose  : Decode/writeback bus into the register file and scoreboard.
// Revision : 1.0
// ============================================================================
interface regfile_bypass_sb_if #(
   parameter int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
   parameter int NUM_READ      = 2
);
   import regfile_pkg::*;

   logic [NUM_READ-1:0][ADDRESS_WIDTH-1:0] rd_addr;
   logic [NUM_READ-1:0][DATA_WIDTH-1:0]    rd_data;
   logic [NUM_READ-1:0]                    rd_busy;
   logic [1:0]                             we;
   logic [1:0][ADDRESS_WIDTH-1:0]          wr_addr;
   logic [1:0][DATA_WIDTH-1:0]             wr_data;
   logic                                   sb_set;
   logic [ADDRESS_WIDTH-1:0]               sb_addr;
   logic [DATA_WIDTH-1:0]                  dbg_data;

   modport master (
      output rd_addr, we, wr_addr, wr_data, sb_set, sb_addr,
      input  rd_data, rd_busy, dbg_data
   );

   modport slave (
      input  rd_addr, we, wr_addr, wr_data, sb_set, sb_addr,
      output rd_data, rd_busy, dbg_data
   );

endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Per-register pending-write bits with per-read-port busy lookup.
// Revision : 1.0
// ============================================================================
module regfile_scoreboard #(
   parameter int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
   parameter int NUM_READ      = 2,
   parameter int BYPASS        = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   sb_set,
   input  logic [ADDRESS_WIDTH-1:0]               sb_addr,
   input  logic [1:0]                             wr_eff,
   input  logic [1:0][ADDRESS_WIDTH-1:0]          wr_addr,
   input  logic [NUM_READ-1:0][ADDRESS_WIDTH-1:0] rd_addr,
   output logic [NUM_READ-1:0]                    rd_busy
);
   import regfile_pkg::*;

   localparam int c_depth = 2**ADDRESS_WIDTH;

   logic [c_depth-1:0] busy;
   logic [c_depth-1:0] busy_nxt;
   logic               wr_hit;

   // Set is applied after clear: a newly issued load is younger than the writeback.
   always_comb begin
      busy_nxt = busy;
      for (int k = 0; k < 2; k++) begin
         if (wr_eff[k]) busy_nxt[wr_addr[k]] = 1'b0;
      end
      if (sb_set && (sb_addr != '0)) busy_nxt[sb_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   always_comb begin
      rd_busy = '0;
      wr_hit  = 1'b0;
      for (int i = 0; i < NUM_READ; i++) begin
         wr_hit = (wr_eff[WB_ALU]  && (wr_addr[WB_ALU]  == rd_addr[i])) ||
                  (wr_eff[WB_LOAD] && (wr_addr[WB_LOAD] == rd_addr[i]));
         rd_busy[i] = busy[rd_addr[i]] && !((BYPASS != 0) && wr_hit);
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_bypass_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bypass_sb
// Purpose  : Multi-read, dual-write register file with bypass and scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_bypass_sb #(
   parameter int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
   parameter int NUM_READ      = 2,
   parameter int BYPASS        = 1,
   parameter int DEBUG_REG     = 10
) (
   input  logic               clk,
   input  logic               rst,
   regfile_bypass_sb_if.slave bus
);
   import regfile_pkg::*;

   localparam int                       c_depth   = 2**ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] c_dbg_idx = ADDRESS_WIDTH'(DEBUG_REG);

   logic [DATA_WIDTH-1:0] mem [c_depth];
   logic [1:0]            wr_eff;
   logic [DATA_WIDTH-1:0] rd_val;

   // A write is effective only outside reset and never to r0.
   always_comb begin
      wr_eff = '0;
      for (int k = 0; k < 2; k++) begin
         wr_eff[k] = !rst && bus.we[k] && (bus.wr_addr[k] != '0);
      end
   end

   // Load port is written last so it wins an address collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < c_depth; r++) mem[r] <= '0;
      end else begin
         if (wr_eff[WB_ALU])  mem[bus.wr_addr[WB_ALU]]  <= bus.wr_data[WB_ALU];
         if (wr_eff[WB_LOAD]) mem[bus.wr_addr[WB_LOAD]] <= bus.wr_data[WB_LOAD];
      end
   end

   always_comb begin
      bus.rd_data = '0;
      rd_val      = '0;
      for (int i = 0; i < NUM_READ; i++) begin
         rd_val = mem[bus.rd_addr[i]];
         if (BYPASS != 0) begin
            if (wr_eff[WB_ALU]  && (bus.wr_addr[WB_ALU]  == bus.rd_addr[i])) rd_val = bus.wr_data[WB_ALU];
            if (wr_eff[WB_LOAD] && (bus.wr_addr[WB_LOAD] == bus.rd_addr[i])) rd_val = bus.wr_data[WB_LOAD];
         end
         if (bus.rd_addr[i] == '0) rd_val = '0;
         bus.rd_data[i] = rd_val;
      end
   end

   assign bus.dbg_data = mem[c_dbg_idx];

   regfile_scoreboard #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .NUM_READ      (NUM_READ),
      .BYPASS        (BYPASS)
   ) u_scoreboard (
      .clk     (clk),
      .rst     (rst),
      .sb_set  (bus.sb_set),
      .sb_addr (bus.sb_addr),
      .wr_eff  (wr_eff),
      .wr_addr (bus.wr_addr),
      .rd_addr (bus.rd_addr),
      .rd_busy (bus.rd_busy)
   );

endmodule
`default_nettype wire
